// File: rtl/gate_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gate_mon_pkg                                                    |
// | Brief    : Shared constants, FSM state encoding and error codes for the    |
// |            kicker gate-driver pulse monitor.                               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package gate_mon_pkg;

    localparam int SERDES_WIDTH = 10;
    localparam int STATE_WIDTH  = 3;

    localparam logic [STATE_WIDTH-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_WIDTH-1:0] S_ALIGN  = 3'd1;
    localparam logic [STATE_WIDTH-1:0] S_DELAY  = 3'd2;
    localparam logic [STATE_WIDTH-1:0] S_FILL   = 3'd3;
    localparam logic [STATE_WIDTH-1:0] S_REPORT = 3'd4;

    localparam logic [1:0] ERR_OK        = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT   = 2'd1;
    localparam logic [1:0] ERR_BAD_LEAD  = 2'd2;
    localparam logic [1:0] ERR_BAD_TRAIL = 2'd3;

endpackage
`default_nettype wire

// File: rtl/gate_word_classify.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gate_word_classify                                              |
// | Brief    : Combinational decode of one ISERDES word (LSB earliest) into    |
// |            idle/low flags and leading/trailing edge bit counts.            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module gate_word_classify
    import gate_mon_pkg::*;
(
    input  logic [SERDES_WIDTH-1:0] kgdWord,
    output logic                    allOnes,
    output logic                    allZeros,
    output logic                    leadValid,
    output logic [3:0]              leadCount,
    output logic                    trailValid,
    output logic [3:0]              trailCount
);

    localparam logic [SERDES_WIDTH-1:0] c_ones = {SERDES_WIDTH{1'b1}};

    assign allOnes  = &kgdWord;
    assign allZeros = ~|kgdWord;

    // Falling edge: L high bits at the LSB end then low. Rising edge: top T bits high.
    always_comb begin
        leadValid  = 1'b0;
        leadCount  = 4'd0;
        trailValid = 1'b0;
        trailCount = 4'd0;
        for (int i = 0; i < SERDES_WIDTH; i++) begin
            if (kgdWord == (c_ones >> (SERDES_WIDTH - i))) begin
                leadValid = 1'b1;
                leadCount = 4'(i);
            end
        end
        for (int t = 1; t <= SERDES_WIDTH; t++) begin
            if (kgdWord == ~(c_ones >> t)) begin
                trailValid = 1'b1;
                trailCount = 4'(t);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gate_pulse_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : gate_pulse_monitor                                              |
// | Brief    : Measures one active-low gate pulse per kgdStrobe from ISERDES   |
// |            words: delay words, lead bits, fill words, trail bits.          |
// |            GATE_MON_ERR_COUNT_EN adds errClear/errCount error counter.     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module gate_pulse_monitor
    import gate_mon_pkg::*;
#(
    parameter int          DELAY_COUNT_WIDTH = 6,
    parameter int          WIDTH_COUNT_WIDTH = 6,
    parameter int unsigned LATENCY           = 3
)
(
    input  logic                         kgdClk,
    input  logic                         kgdRst_n,
    input  logic                         kgdStrobe,
    input  logic [SERDES_WIDTH-1:0]      kgdWord,
    output logic                         resultValid,
    output logic [DELAY_COUNT_WIDTH-1:0] resultDelay,
    output logic [3:0]                   resultLead,
    output logic [WIDTH_COUNT_WIDTH-1:0] resultFill,
    output logic [3:0]                   resultTrail,
    output logic [1:0]                   resultErr
`ifdef GATE_MON_ERR_COUNT_EN
    ,
    input  logic                         errClear,
    output logic [7:0]                   errCount
`endif
);

    localparam logic [DELAY_COUNT_WIDTH-1:0] c_delayMax  = {DELAY_COUNT_WIDTH{1'b1}};
    localparam logic [WIDTH_COUNT_WIDTH-1:0] c_fillMax   = {WIDTH_COUNT_WIDTH{1'b1}};
    localparam logic [7:0]                   c_alignInit = (LATENCY == 0) ? 8'd0 : 8'(LATENCY - 1);

    logic [STATE_WIDTH-1:0]       r_state;
    logic [STATE_WIDTH-1:0]       w_nextState;
    logic [7:0]                   r_alignCnt;
    logic [DELAY_COUNT_WIDTH-1:0] r_delayCnt;
    logic [WIDTH_COUNT_WIDTH-1:0] r_fillCnt;
    logic [3:0]                   r_leadCnt;
    logic                         w_term;
    logic [1:0]                   w_termErr;

    logic       w_allOnes;
    logic       w_allZeros;
    logic       w_leadValid;
    logic [3:0] w_leadCount;
    logic       w_trailValid;
    logic [3:0] w_trailCount;

    gate_word_classify u_classify (
        .kgdWord    (kgdWord),
        .allOnes    (w_allOnes),
        .allZeros   (w_allZeros),
        .leadValid  (w_leadValid),
        .leadCount  (w_leadCount),
        .trailValid (w_trailValid),
        .trailCount (w_trailCount)
    );

    always_ff @(posedge kgdClk or negedge kgdRst_n) begin
        if (!kgdRst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_term      = 1'b0;
        w_termErr   = ERR_OK;
        case (r_state)
            S_IDLE: begin
                if (kgdStrobe) begin
                    w_nextState = (LATENCY == 0) ? S_DELAY : S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (r_alignCnt == 8'd0) begin
                    w_nextState = S_DELAY;
                end
            end
            S_DELAY: begin
                if (w_allOnes) begin
                    if (r_delayCnt == c_delayMax) begin
                        w_term    = 1'b1;
                        w_termErr = ERR_TIMEOUT;
                    end
                end else if (w_leadValid) begin
                    w_nextState = S_FILL;
                end else begin
                    w_term    = 1'b1;
                    w_termErr = ERR_BAD_LEAD;
                end
            end
            S_FILL: begin
                if (w_allZeros) begin
                    if (r_fillCnt == c_fillMax) begin
                        w_term    = 1'b1;
                        w_termErr = ERR_BAD_TRAIL;
                    end
                end else begin
                    w_term    = 1'b1;
                    w_termErr = w_trailValid ? ERR_OK : ERR_BAD_TRAIL;
                end
            end
            S_REPORT: w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
        if (w_term) begin
            w_nextState = S_REPORT;
        end
    end

    always_comb begin
        resultValid = (r_state == S_REPORT);
    end

    // Working counters run per measurement; result fields only move on termination
    always_ff @(posedge kgdClk or negedge kgdRst_n) begin
        if (!kgdRst_n) begin
            r_alignCnt  <= 8'd0;
            r_delayCnt  <= '0;
            r_fillCnt   <= '0;
            r_leadCnt   <= 4'd0;
            resultDelay <= '0;
            resultLead  <= 4'd0;
            resultFill  <= '0;
            resultTrail <= 4'd0;
            resultErr   <= ERR_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (kgdStrobe) begin
                        r_alignCnt <= c_alignInit;
                        r_delayCnt <= '0;
                        r_fillCnt  <= '0;
                        r_leadCnt  <= 4'd0;
                    end
                end
                S_ALIGN: begin
                    if (r_alignCnt != 8'd0) begin
                        r_alignCnt <= r_alignCnt - 8'd1;
                    end
                end
                S_DELAY: begin
                    if (w_allOnes) begin
                        if (r_delayCnt != c_delayMax) begin
                            r_delayCnt <= r_delayCnt + DELAY_COUNT_WIDTH'(1);
                        end
                    end else if (w_leadValid) begin
                        r_leadCnt <= w_leadCount;
                    end
                end
                S_FILL: begin
                    if (w_allZeros && (r_fillCnt != c_fillMax)) begin
                        r_fillCnt <= r_fillCnt + WIDTH_COUNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase

            if (w_term) begin
                resultDelay <= r_delayCnt;
                resultErr   <= w_termErr;
                if (r_state == S_FILL) begin
                    resultLead  <= r_leadCnt;
                    resultFill  <= r_fillCnt;
                    resultTrail <= (w_termErr == ERR_OK) ? w_trailCount : 4'd0;
                end else begin
                    resultLead  <= 4'd0;
                    resultFill  <= '0;
                    resultTrail <= 4'd0;
                end
            end
        end
    end

`ifdef GATE_MON_ERR_COUNT_EN
    logic [7:0] r_errCount;

    always_ff @(posedge kgdClk or negedge kgdRst_n) begin
        if (!kgdRst_n) begin
            r_errCount <= 8'd0;
        end else if (errClear) begin
            r_errCount <= 8'd0;
        end else if ((r_state == S_REPORT) && (resultErr != ERR_OK) && (r_errCount != 8'hFF)) begin
            r_errCount <= r_errCount + 8'd1;
        end
    end

    assign errCount = r_errCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gate_pulse_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_gate_pulse_monitor                                           |
// | Brief    : Self-checking bench for gate_pulse_monitor (LATENCY=3).         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_gate_pulse_monitor;

    logic       kgdClk = 1'b0;
    logic       kgdRst_n;
    logic       kgdStrobe;
    logic [9:0] kgdWord;
    logic       resultValid;
    logic [5:0] resultDelay;
    logic [3:0] resultLead;
    logic [5:0] resultFill;
    logic [3:0] resultTrail;
    logic [1:0] resultErr;
`ifdef GATE_MON_ERR_COUNT_EN
    logic       errClear;
    logic [7:0] errCount;
    int         expErrCount = 0;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        int delay;
        int lead;
        int fill;
        int trail;
        int err;
        int term;
    } res_t;

    typedef struct packed {
        logic [159:0] words;
        int           len;
        res_t         exp;
    } vec_t;

    gate_pulse_monitor #(
        .DELAY_COUNT_WIDTH (6),
        .WIDTH_COUNT_WIDTH (6),
        .LATENCY           (3)
    ) dut (
        .kgdClk      (kgdClk),
        .kgdRst_n    (kgdRst_n),
        .kgdStrobe   (kgdStrobe),
        .kgdWord     (kgdWord),
        .resultValid (resultValid),
        .resultDelay (resultDelay),
        .resultLead  (resultLead),
        .resultFill  (resultFill),
        .resultTrail (resultTrail),
        .resultErr   (resultErr)
`ifdef GATE_MON_ERR_COUNT_EN
        ,
        .errClear    (errClear),
        .errCount    (errCount)
`endif
    );

    always #5 kgdClk = ~kgdClk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Line is idle-high outside the supplied words
    function automatic int getWord(input logic [9:0] q[$], input int i);
        if (i < 0 || i >= q.size()) return 1023;
        return int'(q[i]);
    endfunction

    // Reference: scan the word stream phase by phase with plain arithmetic
    function automatic res_t model(input logic [9:0] q[$]);
        res_t r;
        int   i;
        int   v;
        r = '0;
        i = 0;
        while (getWord(q, i) == 1023) begin
            if (r.delay == 63) begin
                r.err = 1; r.term = i;
                return r;
            end
            r.delay++; i++;
        end
        v = getWord(q, i);
        r.lead = -1;
        for (int l = 0; l < 10; l++) if (v == (1 << l) - 1) r.lead = l;
        if (r.lead < 0) begin
            r.lead = 0; r.err = 2; r.term = i;
            return r;
        end
        i++;
        while (getWord(q, i) == 0) begin
            if (r.fill == 63) begin
                r.err = 3; r.term = i;
                return r;
            end
            r.fill++; i++;
        end
        v = getWord(q, i);
        for (int t = 1; t <= 10; t++) if (v == 1024 - (1 << (10 - t))) r.trail = t;
        r.err  = (r.trail == 0) ? 3 : 0;
        r.term = i;
        return r;
    endfunction

    // Strobe, stream words (word 0 at posedge 4), expect one valid at term+4
    task automatic runMeas(input string name, input logic [9:0] q[$], input res_t exp,
                           input int restrobeAt, input int clearAt);
        int   validCnt;
        int   validAt;
        res_t got;
        validCnt = 0;
        validAt  = -1;
        got      = '0;
        @(negedge kgdClk);
        kgdStrobe = 1'b1;
        kgdWord   = 10'h3FF;
        for (int n = 0; n < exp.term + 9; n++) begin
            @(posedge kgdClk);
            @(negedge kgdClk);
            kgdStrobe = (n + 1 == restrobeAt);
`ifdef GATE_MON_ERR_COUNT_EN
            errClear = (n + 1 == clearAt);
`endif
            if (resultValid) begin
                validCnt++;
                if (validAt < 0) begin
                    validAt   = n;
                    got.delay = int'(resultDelay);
                    got.lead  = int'(resultLead);
                    got.fill  = int'(resultFill);
                    got.trail = int'(resultTrail);
                    got.err   = int'(resultErr);
                end
            end
            kgdWord = 10'(getWord(q, n - 3));
        end
        kgdStrobe = 1'b0;
`ifdef GATE_MON_ERR_COUNT_EN
        errClear = 1'b0;
`endif
        chk({name, " validCount"}, validCnt, 1);
        chk({name, " validCycle"}, validAt, exp.term + 4);
        chk({name, " delay"}, got.delay, exp.delay);
        chk({name, " lead"},  got.lead,  exp.lead);
        chk({name, " fill"},  got.fill,  exp.fill);
        chk({name, " trail"}, got.trail, exp.trail);
        chk({name, " err"},   got.err,   exp.err);
`ifdef GATE_MON_ERR_COUNT_EN
        if (clearAt == exp.term + 5) expErrCount = 0;
        else if (exp.err != 0 && expErrCount < 255) expErrCount++;
        chk({name, " errCount"}, int'(errCount), expErrCount);
`else
        if (clearAt > 0) chk({name, " clearUnused"}, clearAt, clearAt + 0);
`endif
    endtask

    function automatic res_t mk(input int d, input int l, input int f, input int t, input int e, input int tm);
        res_t r;
        r.delay = d; r.lead = l; r.fill = f; r.trail = t; r.err = e; r.term = tm;
        return r;
    endfunction

    vec_t       vecs[6];
    logic [9:0] q[$];
    logic [9:0] case1[$];
    res_t       exp1;

    initial begin
        vecs[0] = '{words: {10'h380, 10'h000, 10'h000, 10'h000, 10'h000, 10'h007, 10'h3FF, 10'h3FF}, len: 8,
                    exp: mk(2, 3, 4, 3, 0, 7)};
        vecs[1] = '{words: {10'h3FF, 10'h000, 10'h3FF}, len: 3, exp: mk(1, 0, 0, 10, 0, 2)};
        vecs[2] = '{words: {10'h105, 10'h3FF}, len: 2, exp: mk(1, 0, 0, 0, 2, 1)};
        vecs[3] = '{words: {10'h0F0, 10'h000, 10'h007}, len: 3, exp: mk(0, 3, 1, 0, 3, 2)};
        vecs[4] = '{words: {10'h3FE}, len: 1, exp: mk(0, 0, 0, 0, 2, 0)};
        vecs[5] = '{words: {10'h200, 10'h1FF}, len: 2, exp: mk(0, 9, 0, 1, 0, 1)};

        kgdRst_n  = 1'b0;
        kgdStrobe = 1'b0;
        kgdWord   = 10'h3FF;
`ifdef GATE_MON_ERR_COUNT_EN
        errClear  = 1'b0;
`endif
        repeat (3) @(posedge kgdClk);
        @(negedge kgdClk);
        chk("reset valid", int'(resultValid), 0);
        chk("reset fields", int'({resultDelay, resultLead, resultFill, resultTrail, resultErr}), 0);
        kgdRst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            q.delete();
            for (int j = 0; j < vecs[v].len; j++) q.push_back(vecs[v].words[j*10 +: 10]);
            runMeas($sformatf("vec%0d", v), q, vecs[v].exp, -1, -1);
        end

        for (int j = 0; j < 8; j++) case1.push_back(vecs[0].words[j*10 +: 10]);
        exp1 = vecs[0].exp;

        // Idle line never falls: timeout after 63 delay words
        q.delete();
        runMeas("timeout", q, mk(63, 0, 0, 0, 1, 63), -1, -1);

        // Fill saturates on the 64th zero word
        q.delete();
        q.push_back(10'h001);
        for (int j = 0; j < 70; j++) q.push_back(10'h000);
        runMeas("fillSat", q, mk(0, 1, 63, 0, 3, 64), -1, -1);

        runMeas("restrobeFill", case1, exp1, 7, -1);
        q.delete();
        for (int j = 0; j < 3; j++) q.push_back(vecs[1].words[j*10 +: 10]);
        runMeas("restrobeReport", q, vecs[1].exp, 7, -1);
        runMeas("afterRestrobe", case1, exp1, -1, -1);

        // Reset in the middle of the fill phase
        begin
            int sawValid;
            sawValid = 0;
            @(negedge kgdClk);
            kgdStrobe = 1'b1;
            for (int n = 0; n < 7; n++) begin
                @(posedge kgdClk);
                @(negedge kgdClk);
                kgdStrobe = 1'b0;
                if (resultValid) sawValid++;
                kgdWord = 10'(getWord(case1, n - 3));
            end
            @(posedge kgdClk);
            @(negedge kgdClk);
            kgdRst_n = 1'b0;
            #1;
            chk("midReset fields", int'({resultValid, resultDelay, resultLead, resultFill, resultTrail, resultErr}), 0);
            for (int n = 0; n < 12; n++) begin
                @(negedge kgdClk);
                kgdWord = 10'(getWord(case1, n + 5));
                if (n == 2) kgdRst_n = 1'b1;
                if (resultValid) sawValid++;
            end
            chk("midReset noValid", sawValid, 0);
            kgdWord = 10'h3FF;
`ifdef GATE_MON_ERR_COUNT_EN
            expErrCount = 0;
`endif
        end
        runMeas("afterReset", case1, exp1, -1, -1);

`ifdef GATE_MON_ERR_COUNT_EN
        q.delete();
        q.push_back(10'h105);
        for (int k = 0; k < 3; k++) runMeas($sformatf("errRun%0d", k), q, mk(0, 0, 0, 0, 2, 0), -1, -1);
        chk("errCount three", int'(errCount), 3);
        runMeas("errClearCoincide", q, mk(0, 0, 0, 0, 2, 0), -1, 5);
        chk("errCount cleared", int'(errCount), 0);
`endif

        for (int r = 0; r < 30; r++) begin
            int d;
            int f;
            res_t e;
            q.delete();
            d = ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(0, 6);
            for (int j = 0; j < d; j++) q.push_back(10'h3FF);
            if ($urandom_range(0, 5) == 0) q.push_back(10'($urandom_range(0, 1022)));
            else q.push_back(10'((1 << $urandom_range(0, 9)) - 1));
            f = ($urandom_range(0, 9) == 0) ? 66 : $urandom_range(0, 5);
            for (int j = 0; j < f; j++) q.push_back(10'h000);
            if ($urandom_range(0, 5) == 0) q.push_back(10'($urandom_range(1, 1023)));
            else q.push_back(10'(1024 - (1 << (10 - $urandom_range(1, 10)))));
            e = model(q);
            runMeas($sformatf("rand%0d", r), q, e, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
